// File: rtl/bnn_conv.sv
`default_nettype none
// ============================================================================
// Module      : bnn_conv
// Description : Streaming KxK binary-weight convolution engine. Raster-order
//               pixels feed K-1 column-indexed line buffers and a KxK window.
//               Each valid (unpadded, stride-1) window is reduced with +/-1
//               weights and the signed sum is registered out two cycles after
//               the window's bottom-right pixel is accepted.
//               Optional build macro CONV_RELU_EN clamps negative sums to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_conv #(
    parameter int DATA_W = 32,
    parameter int K      = 5,
    parameter int IMG0_W = 28,
    parameter int IMG1_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     state,
    input  logic                     weight_en,
    input  logic                     weight,
    input  logic                     din_valid,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout,
    output logic                     ovalid,
    output logic                     done
);

    localparam int CW = $clog2(IMG0_W);
    localparam int NW = K * K;
    localparam logic [CW-1:0] c_last0 = CW'(IMG0_W - 1);
    localparam logic [CW-1:0] c_last1 = CW'(IMG1_W - 1);
    localparam logic [CW-1:0] c_kmin  = CW'(K - 1);

    logic [NW-1:0]              r_wsr;
    logic [CW-1:0]              r_col;
    logic [CW-1:0]              r_row;
    logic                       r_mode;
    logic signed [DATA_W-1:0]   r_lb  [K-1][IMG0_W];
    logic signed [DATA_W-1:0]   r_win [K][K];
    logic                       r_wv;
    logic                       r_wlast;

    logic                       w_acc;
    logic                       w_first;
    logic                       w_mode;
    logic [CW-1:0]              w_last;
    logic signed [DATA_W-1:0]   w_col_vec [K];
    logic signed [DATA_W-1:0]   w_sum;
    logic signed [DATA_W-1:0]   w_res;

    assign w_acc   = start & din_valid;
    assign w_first = (r_col == '0) && (r_row == '0);
    // Pixel (0,0) uses the live mode input; the rest of the frame uses the latch.
    assign w_mode  = w_first ? state : r_mode;
    assign w_last  = w_mode ? c_last1 : c_last0;

    // Assemble the incoming column: oldest buffered row at the top, new pixel at the bottom.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_col_vec[i] = '0;
        end
        w_col_vec[K-1] = din;
        for (int k = 0; k < K-1; k++) begin
            w_col_vec[K-2-k] = r_lb[k][r_col];
        end
    end

    // Serial weight shift register; the first bit loaded ends up in the MSB (top-left tap).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wsr <= '0;
        end else if (weight_en) begin
            r_wsr <= {r_wsr[NW-2:0], weight};
        end
    end

    // Raster position counters and per-frame mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 1'b0;
        end else if (w_acc) begin
            if (w_first) begin
                r_mode <= state;
            end
            if (r_col == w_last) begin
                r_col <= '0;
                r_row <= (r_row == w_last) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers indexed by column: each accept pushes the column down one row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < K-1; k++) begin
                for (int c = 0; c < IMG0_W; c++) begin
                    r_lb[k][c] <= '0;
                end
            end
        end else if (w_acc) begin
            r_lb[0][r_col] <= din;
            for (int k = 1; k < K-1; k++) begin
                r_lb[k][r_col] <= r_lb[k-1][r_col];
            end
        end
    end

    // KxK window shifts left one column per accept, new column enters on the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_acc) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
                r_win[i][K-1] <= w_col_vec[i];
            end
        end
    end

    // Window-valid and end-of-frame flags travel alongside the freshly loaded window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wv    <= 1'b0;
            r_wlast <= 1'b0;
        end else begin
            r_wv    <= w_acc && (r_row >= c_kmin) && (r_col >= c_kmin);
            r_wlast <= w_acc && (r_row == w_last) && (r_col == w_last);
        end
    end

    // +/-1 reduction over the window with the weights current at compute time.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                if (r_wsr[NW-1-(i*K+j)]) begin
                    w_sum = w_sum + r_win[i][j];
                end else begin
                    w_sum = w_sum - r_win[i][j];
                end
            end
        end
    end

`ifdef CONV_RELU_EN
    assign w_res = w_sum[DATA_W-1] ? '0 : w_sum;
`else
    assign w_res = w_sum;
`endif

    // Output register: dout only updates on a valid window, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            ovalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            ovalid <= r_wv;
            done   <= r_wlast;
            if (r_wv) begin
                dout <= w_res;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_conv
// Description : Directed self-checking bench for bnn_conv (frame sums, done
//               placement, mode latching, latency under gaps, reset abort,
//               back-to-back frames, weight ordering).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_conv;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               state;
    logic               weight_en;
    logic               weight;
    logic               din_valid;
    logic signed [31:0] din;
    logic signed [31:0] dout;
    logic               ovalid;
    logic               done;

    bnn_conv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state     (state),
        .weight_en (weight_en),
        .weight    (weight),
        .din_valid (din_valid),
        .din       (din),
        .dout      (dout),
        .ovalid    (ovalid),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    logic signed [31:0] q_val [$];
    bit                 q_done[$];
    int                 q_cyc [$];
    int                 q_acc [$];
    int                 stray_done = 0;
    int                 hold_err   = 0;
    logic signed [31:0] last_dout;

    // Output monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (ovalid === 1'b1) begin
            q_val.push_back(dout);
            q_done.push_back(done);
            q_cyc.push_back(cyc);
        end else if (dout !== last_dout) begin
            hold_err++;
        end
        if (done === 1'b1 && ovalid !== 1'b1) stray_done++;
        last_dout = dout;
    end

    function automatic int exp_r(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0: return 1;
            1: return 2;
            2: return r;
            default: return r * 16 + c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_val.delete();
        q_done.delete();
        q_cyc.delete();
        q_acc.delete();
        stray_done = 0;
    endtask

    task automatic load_w(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            weight_en = 1'b1;
            weight    = b;
            tick();
        end
        weight_en = 1'b0;
        weight    = 1'b0;
    endtask

    // Drives npix pixels of a frame; state flips after pixel (0,0) to prove latching.
    task automatic send_frame(input bit mode, input int kind, input bit gap, input int npix);
        int w;
        int n;
        w = mode ? 12 : 28;
        n = 0;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n < npix) begin
                    start     = 1'b1;
                    din_valid = 1'b1;
                    state     = (r == 0 && c == 0) ? mode : ~mode;
                    din       = pix(kind, r, c);
                    if (r >= 4 && c >= 4) q_acc.push_back(cyc);
                    tick();
                    if (gap) begin
                        start     = c[0] ? 1'b0 : 1'b1;
                        din_valid = c[0] ? 1'b1 : 1'b0;
                        din       = 32'sd12345;
                        tick();
                    end
                    n++;
                end
            end
        end
        start     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; state = 1'b0; weight_en = 1'b0; weight = 1'b0;
        din_valid = 1'b0; din = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vectors++; if (dout !== 32'sd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        vectors++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    // Weights left at reset value 0 (all -1), pixels 2 -> -50.
    task automatic test_all_neg();
        clear_q();
        send_frame(1'b0, 1, 1'b0, 784);
        drain();
        vectors++; if (q_val.size() !== 576) begin errors++; $display("FAIL neg_count: got %0d expected 576", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            vectors++; if (q_val[k] !== exp_r(-50)) begin errors++; $display("FAIL neg_val[%0d]: got %0d expected %0d", k, q_val[k], exp_r(-50)); end
            vectors++; if (q_done[k] !== (k == 575)) begin errors++; $display("FAIL neg_done[%0d]: got %b expected %b", k, q_done[k], (k == 575)); end
        end
        vectors++; if (stray_done !== 0) begin errors++; $display("FAIL neg_stray_done: got %0d expected 0", stray_done); end
    endtask

    task automatic test_all_ones();
        load_w(1'b1, 25);
        clear_q();
        send_frame(1'b0, 0, 1'b0, 784);
        drain();
        vectors++; if (q_val.size() !== 576) begin errors++; $display("FAIL ones_count: got %0d expected 576", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            vectors++; if (q_val[k] !== 32'sd25) begin errors++; $display("FAIL ones_val[%0d]: got %0d expected 25", k, q_val[k]); end
            vectors++; if (q_done[k] !== (k == 575)) begin errors++; $display("FAIL ones_done[%0d]: got %b expected %b", k, q_done[k], (k == 575)); end
        end
    endtask

    // Mode 1, pixel = row index -> output row a gives 25a+50.
    task automatic test_mode1_rows();
        clear_q();
        send_frame(1'b1, 2, 1'b0, 144);
        drain();
        vectors++; if (q_val.size() !== 64) begin errors++; $display("FAIL rows_count: got %0d expected 64", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            vectors++; if (q_val[k] !== 25 * (k / 8) + 50) begin errors++; $display("FAIL rows_val[%0d]: got %0d expected %0d", k, q_val[k], 25 * (k / 8) + 50); end
            vectors++; if (q_done[k] !== (k == 63)) begin errors++; $display("FAIL rows_done[%0d]: got %b expected %b", k, q_done[k], (k == 63)); end
        end
    endtask

    // 30 bits loaded, last 25 are 1 then 24 zeros -> only w[0][0] is +1.
    // Pixel 16r+c, window top-left (a,b): 2*p(a,b) - (400a+25b+850) = -368a-23b-850.
    task automatic test_weight_order();
        load_w(1'b1, 5);
        load_w(1'b1, 1);
        load_w(1'b0, 24);
        clear_q();
        send_frame(1'b1, 3, 1'b0, 144);
        drain();
        vectors++; if (q_val.size() !== 64) begin errors++; $display("FAIL word_count: got %0d expected 64", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            int e;
            e = exp_r(-368 * (k / 8) - 23 * (k % 8) - 850);
            vectors++; if (q_val[k] !== e) begin errors++; $display("FAIL word_val[%0d]: got %0d expected %0d", k, q_val[k], e); end
        end
    endtask

    task automatic test_gapped();
        load_w(1'b1, 25);
        clear_q();
        hold_err = 0;
        send_frame(1'b0, 0, 1'b1, 784);
        drain();
        vectors++; if (q_val.size() !== 576) begin errors++; $display("FAIL gap_count: got %0d expected 576", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            vectors++; if (q_val[k] !== 32'sd25) begin errors++; $display("FAIL gap_val[%0d]: got %0d expected 25", k, q_val[k]); end
            vectors++; if (q_done[k] !== (k == 575)) begin errors++; $display("FAIL gap_done[%0d]: got %b expected %b", k, q_done[k], (k == 575)); end
            if (k < q_acc.size()) begin
                vectors++; if (q_cyc[k] !== q_acc[k] + 2) begin errors++; $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", k, q_cyc[k], q_acc[k] + 2); end
            end
        end
        vectors++; if (hold_err !== 0) begin errors++; $display("FAIL gap_hold: got %0d changes expected 0", hold_err); end
    endtask

    task automatic test_reset_midframe();
        send_frame(1'b0, 0, 1'b0, 300);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        vectors++; if (ovalid !== 1'b0) begin errors++; $display("FAIL mid_rst_ovalid: got %b expected 0", ovalid); end
        load_w(1'b1, 25);
        clear_q();
        send_frame(1'b0, 0, 1'b0, 784);
        drain();
        vectors++; if (q_val.size() !== 576) begin errors++; $display("FAIL mid_count: got %0d expected 576", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            vectors++; if (q_val[k] !== 32'sd25) begin errors++; $display("FAIL mid_val[%0d]: got %0d expected 25", k, q_val[k]); end
            vectors++; if (q_done[k] !== (k == 575)) begin errors++; $display("FAIL mid_done[%0d]: got %b expected %b", k, q_done[k], (k == 575)); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(1'b1, 2, 1'b0, 144);
        send_frame(1'b0, 0, 1'b0, 784);
        drain();
        vectors++; if (q_val.size() !== 640) begin errors++; $display("FAIL b2b_count: got %0d expected 640", q_val.size()); end
        for (int k = 0; k < q_val.size(); k++) begin
            int e;
            e = (k < 64) ? 25 * (k / 8) + 50 : 25;
            vectors++; if (q_val[k] !== e) begin errors++; $display("FAIL b2b_val[%0d]: got %0d expected %0d", k, q_val[k], e); end
            vectors++; if (q_done[k] !== (k == 63 || k == 639)) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, q_done[k], (k == 63 || k == 639)); end
        end
        vectors++; if (stray_done !== 0) begin errors++; $display("FAIL b2b_stray_done: got %0d expected 0", stray_done); end
    endtask

    initial begin
        test_reset();
        test_all_neg();
        test_all_ones();
        test_mode1_rows();
        test_weight_order();
        test_gapped();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
